// File: rtl/ilm_pkg.sv
// Shared types and constants for the iterative logarithmic multiplier (IterLM) sequencer.
package ilm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } ilm_state_t;

    localparam int ILM_WIDTH = 16;
    localparam int ILM_ITERS = 2;

    // Exponent width for a leading-one index; kept at least 1 bit wide.
    function automatic int k_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/ilm_iter_seq_if.sv
// Operand/result handshake bundle for ilm_iter_seq, plus the per-iteration one-hot taps.
interface ilm_iter_seq_if
    import ilm_pkg::*;
#(
    parameter int WIDTH = ILM_WIDTH,
    parameter int ITERS = ILM_ITERS
);
    localparam int CNT_W = $clog2(ITERS + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic [CNT_W-1:0]     iters_used;
    logic [WIDTH-1:0]     o_a;
    logic [WIDTH-1:0]     o_b;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, iters_used, o_a, o_b
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, iters_used, o_a, o_b
    );

endinterface

// File: rtl/ilm_lod.sv
// Combinational leading-one detector: residue -> one-hot MSB, its index k, and a zero flag.
module ilm_lod
    import ilm_pkg::*;
#(
    parameter int WIDTH = ILM_WIDTH,
    parameter int KW    = k_width(WIDTH)
) (
    input  logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] onehot,
    output logic [KW-1:0]    k,
    output logic             zero
);

    always_comb begin
        onehot = '0;
        k      = '0;
        zero   = (res == '0);
        // Ascending scan: the highest set bit is the last one written.
        for (int i = 0; i < WIDTH; i++) begin
            if (res[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                k         = KW'(i);
            end
        end
    end

endmodule

// File: rtl/ilm_iter_seq.sv
// IterLM sequencer: accumulates Mitchell partial products over up to ITERS iterations.
// Build option ILM_EARLY_TERM_EN ends iterating as soon as either residue reaches zero.
module ilm_iter_seq
    import ilm_pkg::*;
#(
    parameter int WIDTH = ILM_WIDTH,
    parameter int ITERS = ILM_ITERS
) (
    input  logic           clk,
    input  logic           rst_n,
    ilm_iter_seq_if.slave  bus
);

    localparam int PW    = 2 * WIDTH;
    localparam int KW    = k_width(WIDTH);
    localparam int CNT_W = $clog2(ITERS + 1);

    ilm_state_t        state_q, state_d;
    logic [WIDTH-1:0]  ra_q, ra_d, rb_q, rb_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0]  oh_a, oh_b;
    logic [KW-1:0]     ka, kb;
    logic              za, zb;
    logic [PW-1:0]     partial;
    logic              last_iter;
    logic              in_ready, out_valid;
    logic [WIDTH-1:0]  o_a, o_b;

    ilm_lod #(.WIDTH(WIDTH), .KW(KW)) u_lod_a (.res(ra_q), .onehot(oh_a), .k(ka), .zero(za));
    ilm_lod #(.WIDTH(WIDTH), .KW(KW)) u_lod_b (.res(rb_q), .onehot(oh_b), .k(kb), .zero(zb));

    // Leading-one term plus the two cross terms; the residue-by-residue term is left to later iterations.
    always_comb begin
        partial = '0;
        if (!za && !zb) begin
            partial = (PW'(1) << (int'(ka) + int'(kb)))
                    + (PW'(ra_q ^ oh_a) << kb)
                    + (PW'(rb_q ^ oh_b) << ka);
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        last_iter = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        o_a       = '0;
        o_b       = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                o_a       = oh_a;
                o_b       = oh_b;
                acc_d     = acc_q + partial;
                ra_d      = ra_q ^ oh_a;
                rb_d      = rb_q ^ oh_b;
                cnt_d     = cnt_q + CNT_W'(1);
                last_iter = (int'(cnt_q) + 1 == ITERS);
`ifdef ILM_EARLY_TERM_EN
                if (ra_d == '0 || rb_d == '0) last_iter = 1'b1;
`endif
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.product    = acc_q;
    assign bus.iters_used = cnt_q;
    assign bus.o_a        = o_a;
    assign bus.o_b        = o_b;

endmodule
